// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: inter-stage pipeline register with valid/ready handshake,
// one-entry skid buffer, flush (clr) and exception-marker (req) insertion.
module pipe_skid_reg #(
    parameter int          DATA_W       = 128,
    parameter int          PC_W         = 32,
    parameter logic [31:0] REQ_INSTR    = 32'h0000_4180,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              delay_slot_in,
    input  logic [4:0]        exc_code_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              delay_slot_out,
    output logic [4:0]        exc_code_out,
    output logic [DATA_W-1:0] data_out,
    output logic              full
);
    localparam int EW = 32 + PC_W + 1 + 5 + DATA_W;
    localparam logic [EW-1:0] BUBBLE = {BUBBLE_INSTR, {(EW-32){1'b0}}};
    localparam logic [EW-1:0] MARKER = {REQ_INSTR, {(EW-32){1'b0}}};

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t        state, state_nx;
    logic [EW-1:0] main_q, main_nx, skid_q, skid_nx, entry_in;
    logic          in_fire, out_fire;

    assign entry_in = {instr_in, pc_in, delay_slot_in, exc_code_in, data_in};
    assign in_ready = state != TWO;
    assign out_valid = state != EMPTY;
    assign full = state == TWO;
    assign in_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign {instr_out, pc_out, delay_slot_out, exc_code_out, data_out} = main_q;

    always_comb begin
        state_nx = state;
        main_nx = main_q;
        skid_nx = skid_q;
        if (req) begin
            state_nx = ONE;
            main_nx = MARKER;
            skid_nx = BUBBLE;
        end else if (clr) begin
            state_nx = EMPTY;
            main_nx = BUBBLE;
            skid_nx = BUBBLE;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = ONE;
                    main_nx = entry_in;
                end
                ONE: if (in_fire && out_fire) begin
                    main_nx = entry_in;
                end else if (in_fire) begin
                    state_nx = TWO;
                    skid_nx = entry_in;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                    main_nx = BUBBLE;
                end
                // in_ready is low in TWO, so only the drain case exists
                TWO: if (out_fire) begin
                    state_nx = ONE;
                    main_nx = skid_q;
                    skid_nx = BUBBLE;
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx = BUBBLE;
                    skid_nx = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench; the reference is a bounded FIFO of
// capacity two holding expected entries, cleared on reset/clr, replaced on req.
module tb_pipe_skid_reg;
    localparam int DATA_W = 128;
    localparam int PC_W = 32;
    localparam int EW = 32 + PC_W + 1 + 5 + DATA_W;
    localparam logic [31:0] REQ_I = 32'h0000_4180;
    localparam logic [31:0] BUB_I = 32'h0000_0000;

    typedef logic [EW-1:0] entry_t;

    logic              clk = 0, reset = 1, clr = 0, req = 0, in_valid = 0, out_ready = 0;
    logic              in_ready, out_valid, full, delay_slot_in = 0, delay_slot_out;
    logic [31:0]       instr_in = 0, instr_out;
    logic [PC_W-1:0]   pc_in = 0, pc_out;
    logic [4:0]        exc_code_in = 0, exc_code_out;
    logic [DATA_W-1:0] data_in = 0, data_out;

    int     vectors = 0, miscompares = 0;
    entry_t q[$];

    pipe_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .REQ_INSTR(REQ_I), .BUBBLE_INSTR(BUB_I)) dut (
        .clk(clk), .reset(reset), .clr(clr), .req(req),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .delay_slot_in(delay_slot_in),
        .exc_code_in(exc_code_in), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .pc_out(pc_out), .delay_slot_out(delay_slot_out),
        .exc_code_out(exc_code_out), .data_out(data_out), .full(full)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(logic [31:0] i, logic [PC_W-1:0] p, logic d, logic [4:0] e, logic [DATA_W-1:0] x);
        return {i, p, d, e, x};
    endfunction

    function automatic entry_t rnd();
        return mk($urandom, $urandom, 1'($urandom), 5'($urandom), {$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic chk(string name, entry_t act, entry_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares presented outputs with the model, pops on accepted output.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("out_valid", entry_t'(out_valid), entry_t'(q.size() != 0));
            chk("in_ready", entry_t'(in_ready), entry_t'(q.size() < 2));
            chk("full", entry_t'(full), entry_t'(q.size() == 2));
            chk("entry", {instr_out, pc_out, delay_slot_out, exc_code_out, data_out},
                q.size() != 0 ? q[0] : mk(BUB_I, 0, 0, 0, 0));
            if (q.size() != 0 && out_ready) void'(q.pop_front());
        end
    end

    // One clock of stimulus; the model is updated after the monitor has sampled.
    task automatic cyc(logic r, logic rq, logic cl, logic v, logic ordy, entry_t e);
        bit room;
        @(posedge clk);
        #1;
        reset = r; req = rq; clr = cl; in_valid = v; out_ready = ordy;
        {instr_in, pc_in, delay_slot_in, exc_code_in, data_in} = e;
        room = q.size() < 2;
        @(negedge clk);
        #1;
        if (r || (cl && !rq)) q.delete();
        else if (rq) begin
            q.delete();
            q.push_back(mk(REQ_I, 0, 0, 0, 0));
        end else if (v && room) q.push_back(e);
    endtask

    task automatic idle(int n, logic ordy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ordy, rnd());
    endtask

    initial begin
        cyc(1, 0, 0, 1, 0, mk(32'h2409_0005, 0, 0, 0, 0));
        cyc(1, 0, 0, 1, 0, mk(32'h2409_0005, 0, 0, 0, 0));
        idle(1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, mk(32'h2409_0000 + i, 32'h3000 + 4 * i, 0, 0, 128'(i)));
        idle(2, 1);
        cyc(0, 0, 0, 1, 0, mk(32'h1111_0000, 32'h3000, 0, 0, 1));
        cyc(0, 0, 0, 1, 0, mk(32'h1111_0004, 32'h3004, 0, 0, 2));
        cyc(0, 0, 0, 1, 0, mk(32'h1111_0008, 32'h3008, 0, 0, 3));
        idle(3, 1);
        cyc(0, 0, 0, 1, 0, rnd());
        cyc(0, 0, 0, 1, 0, rnd());
        cyc(0, 1, 0, 1, 0, rnd());
        idle(2, 1);
        cyc(0, 0, 0, 1, 0, rnd());
        cyc(0, 1, 1, 1, 0, rnd());
        cyc(0, 0, 1, 1, 0, rnd());
        idle(1, 0);
        cyc(0, 0, 0, 1, 0, rnd());
        cyc(0, 0, 1, 1, 0, rnd());
        idle(1, 0);
        cyc(0, 0, 0, 1, 0, mk(32'h0000_0021, 32'h3010, 1, 5'd10, 128'hABC));
        idle(3, 0);
        idle(2, 1);
        for (int i = 0; i < 3000; i++) begin
            int p = $urandom_range(0, 99);
            cyc(p == 0, p == 1 || p == 2, p == 3 || p == 4 || p == 2, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0, rnd());
        end
        idle(3, 1);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
